// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: active-low patterns (bit 0 = segment 0) and the reader FSM state type.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0010001;
  localparam logic [6:0] SEG_C     = 7'b0000110;
  localparam logic [6:0] SEG_E     = 7'b1001000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    LOCKED = 1'b0,
    TRACK  = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_pattern_lookup.sv
// Combinational inverse of the hex decoder: segment pattern to {bad, code}.
module seven_seg_pattern_lookup
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);

  // SEG_1 is also the pattern the forward decoder uses for B and D; it always reads back as 1.
  always_comb begin
    code = 4'hF;
    bad  = 1'b0;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_A:     code = 4'hA;
      SEG_C:     code = 4'hC;
      SEG_E:     code = 4'hE;
      SEG_BLANK: code = 4'hF;
      default: begin
        code = 4'hF;
        bad  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Debounces an active-low segment bus and reports each newly stable pattern once
// through a single-entry valid/ready buffer, flagging unknown patterns and drops.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [3:0] out_code,
  output logic       out_bad,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  input  logic       clear_overrun
);

  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 2);

  logic [6:0] r_samp_q;
  logic [7:0] r_cnt;
  logic [6:0] r_last_acc;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_out_code;
  logic       r_out_bad;
  logic       r_out_valid;
  logic       r_overrun;

  logic       w_diff;
  logic       w_accept;
  logic       w_emit;
  logic       w_drain;
  logic       w_load;
  logic       w_drop;
  logic [3:0] w_code;
  logic       w_bad;

  assign w_diff = (seg_in != r_samp_q);

  seven_seg_pattern_lookup u_lookup (
    .seg  (r_samp_q),
    .code (w_code),
    .bad  (w_bad)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= LOCKED;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == LOCKED) begin
      if (w_diff) w_state_nxt = TRACK;
    end else begin
      if (!w_diff && (r_cnt == ACCEPT_CNT)) w_state_nxt = LOCKED;
    end
  end

  // Accept fires on the STABLE_CYCLES-th equal sample; only a pattern differing from the last accepted one is emitted.
  always_comb begin
    w_accept = (r_state == TRACK) && !w_diff && (r_cnt == ACCEPT_CNT);
    w_emit   = w_accept && (r_samp_q != r_last_acc);
    w_drain  = r_out_valid && out_ready;
    w_load   = w_emit && (!r_out_valid || w_drain);
    w_drop   = w_emit && r_out_valid && !out_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_samp_q   <= SEG_BLANK;
      r_cnt      <= '0;
      r_last_acc <= SEG_BLANK;
    end else begin
      r_samp_q <= seg_in;
      if (w_diff)                r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;
      if (w_emit) r_last_acc <= r_samp_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_code  <= '0;
      r_out_bad   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_code  <= w_code;
        r_out_bad   <= w_bad;
        r_out_valid <= 1'b1;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop)             r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;
    end
  end

  assign out_code  = r_out_code;
  assign out_bad   = r_out_bad;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader with STABLE_CYCLES = 4.
module tb_seven_seg_reader;

  logic       clock;
  logic       reset;
  logic [6:0] seg_in;
  logic [3:0] out_code;
  logic       out_bad;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       clear_overrun;

  int unsigned n_total;
  int unsigned n_bad;
  int unsigned n_out;
  logic [4:0]  sb[$];

  seven_seg_reader #(.STABLE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .seg_in        (seg_in),
    .out_code      (out_code),
    .out_bad       (out_bad),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // A transfer happens on the next rising edge whenever valid & ready are seen here.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check_eq("unexpected_result", {27'd0, out_bad, out_code}, 32'h1FF);
      end else begin
        logic [4:0] exp_r;
        exp_r = sb.pop_front();
        check_eq("result", {27'd0, out_bad, out_code}, {27'd0, exp_r});
      end
    end
  end

  initial begin
    int unsigned base;
    n_total = 0; n_bad = 0; n_out = 0;
    reset = 1'b1; seg_in = 7'h7F; out_ready = 1'b1; clear_overrun = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_code", {28'd0, out_code}, 32'd0);
    check_eq("rst_bad", {31'd0, out_bad}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(6);
    check_eq("blank_no_result", n_out, 32'd0);

    // Code 2 with exact latency, single report while held.
    seg_in = 7'b0100100; sb.push_back({1'b0, 4'h2});
    tick(3);
    check_eq("lat2_early", {31'd0, out_valid}, 32'd0);
    tick(1);
    check_eq("lat2_on", {31'd0, out_valid}, 32'd1);
    tick(10);
    check_eq("code2_once", n_out, 32'd1);

    // Short 3-cycle pattern must be rejected; 0 follows 4 samples after its change.
    seg_in = 7'b0110000; tick(3);
    seg_in = 7'b1000000; sb.push_back({1'b0, 4'h0});
    tick(3);
    check_eq("lat0_early", {31'd0, out_valid}, 32'd0);
    tick(1);
    check_eq("lat0_on", {31'd0, out_valid}, 32'd1);
    tick(8);
    check_eq("code0_only", n_out, 32'd2);

    seg_in = 7'b1111001; sb.push_back({1'b0, 4'h1}); tick(8);
    seg_in = 7'b1111111; sb.push_back({1'b0, 4'hF}); tick(8);
    seg_in = 7'b1011011; sb.push_back({1'b1, 4'hF}); tick(8);
    check_eq("three_results", n_out, 32'd5);

    // Overrun: buffer holds 5 while 6 is dropped.
    out_ready = 1'b0;
    seg_in = 7'b0010010; sb.push_back({1'b0, 4'h5}); tick(6);
    check_eq("ovr_valid", {31'd0, out_valid}, 32'd1);
    check_eq("ovr_code5", {28'd0, out_code}, 32'h5);
    seg_in = 7'b0000010; tick(6);
    check_eq("ovr_hold5", {28'd0, out_code}, 32'h5);
    check_eq("ovr_set", {31'd0, overrun}, 32'd1);
    base = n_out;
    out_ready = 1'b1; tick(8);
    check_eq("ovr_no6", n_out - base, 32'd1);
    check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);
    clear_overrun = 1'b1; tick(1); clear_overrun = 1'b0;
    check_eq("ovr_clear", {31'd0, overrun}, 32'd0);

    // Glitch returning to the accepted pattern produces nothing new.
    seg_in = 7'b0110000; sb.push_back({1'b0, 4'h3}); tick(8);
    base = n_out;
    seg_in = 7'b0000000; tick(1);
    seg_in = 7'b0110000; tick(10);
    check_eq("glitch_silent", n_out - base, 32'd0);

    // Asynchronous reset with a full buffer and a window in progress.
    out_ready = 1'b0;
    seg_in = 7'b1111000; tick(5);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    seg_in = 7'b0100100; tick(2);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_code", {28'd0, out_code}, 32'd0);
    seg_in = 7'h7F;
    tick(2);
    reset = 1'b0; out_ready = 1'b1;
    base = n_out;
    tick(10);
    check_eq("post_rst_silent", n_out - base, 32'd0);
    check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
    seg_in = 7'b0010000; sb.push_back({1'b0, 4'h9}); tick(8);
    check_eq("post_rst_code9", n_out - base, 32'd1);
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Recovers the 4-bit display code from an active-low 7-segment pattern, which is the inverse of the board's `seven_seg_decoder` hex mapping. It sits on the display side of the lab design, monitors a segment bus such as `hex_LEDs`, and debounces the pattern over a programmable number of cycles. Each newly stable pattern is reported once through a single-entry valid/ready output buffer, and unknown patterns and dropped results are flagged.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `seg_in`  in  7: active-low segment pattern, bit 0 = segment 0 … bit 6 = segment 6.
- `out_code`  out  4: recovered code.
- `out_bad`  out  1: pattern not in the table; `out_code` = 4'hF.
- `out_valid`  out  1: output buffer holds an unconsumed result.
- `out_ready`  in  1: consumer accepts the result when high together with `out_valid`.
- `overrun`  out  1: sticky; a result was dropped because the buffer was full.
- `clear_overrun`  in  1: clears `overrun`.

## Operation
- Lookup: inverse map, pattern to code.
  - 7'b1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6.
  - 1111000→7, 0000000→8, 0010000→9, 0010001→A, 0000110→C, 1001000→E, 1111111→F.
  - 1111001 is shared by codes 1, B and D and always decodes to 1.
  - Any other pattern sets `bad`=1 and `code`=4'hF.
- Registers:
  - `samp_q` (7): last sample.
  - `cnt` (8): stability count.
  - `last_acc` (7): last accepted pattern.
  - `state`.
  - Output buffer: `out_code`, `out_bad`, `out_valid`.
  - `overrun`.
- Every edge: `samp_q`←`seg_in`. If `seg_in`≠`samp_q`, then `cnt`←0; otherwise `cnt` increments, saturating at `STABLE_CYCLES`-1.
- States:
  - LOCKED → TRACK when `seg_in`≠`samp_q`.
  - TRACK stays in TRACK, restarting the count, on any change.
  - TRACK → LOCKED when `seg_in`=`samp_q` and `cnt`=`STABLE_CYCLES`-2, so `STABLE_CYCLES` equal samples have been taken. This is the accept event.
- Accept with `samp_q`≠`last_acc`: emit a result and set `last_acc`←`samp_q`.
- Accept with `samp_q`=`last_acc`, e.g. a glitch that returns to the same pattern: no emit, return to LOCKED silently.
- Emit into the output buffer:
  - Buffer empty, or draining this cycle (`out_valid`&`out_ready`): load code/bad; `out_valid`=1.
  - Buffer full and not draining: drop the result, set `overrun`=1, and still update `last_acc`.
- Handshake: transfer occurs on an edge with `out_valid`&`out_ready`.
  - `out_valid` falls after the transfer unless a new result loads on the same edge.
  - `out_code`/`out_bad` are stable while `out_valid`=1 and not transferred.
- `clear_overrun` clears `overrun` on the next edge. A simultaneous set wins.

## Timing
- Reset values:
  - `samp_q`=7'h7F, `last_acc`=7'h7F, `cnt`=0, state LOCKED.
  - `out_valid`=0, `out_code`=0, `out_bad`=0, `overrun`=0.
  - A blank display after reset therefore produces no result.
- Latency: pattern P differs from `samp_q` and is sampled on edges k … k+`STABLE_CYCLES`-1. `out_valid` is high after edge k+`STABLE_CYCLES`-1 when the buffer is empty.
- Any differing sample before accept restarts the window from that edge.
- Reset mid-window or with the buffer full discards everything. No result is emitted for a pattern captured before reset.
- Throughput: at most one result per `STABLE_CYCLES` cycles. The consumer may hold `out_ready` high permanently.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `seven_seg_pkg`:
  - Pattern constants `SEG_0`…`SEG_9`, `SEG_A`, `SEG_C`, `SEG_E`, `SEG_BLANK`.
  - State enum {LOCKED, TRACK}.
  - Shareable with the forward decoder.
- Sub-module `seven_seg_pattern_lookup`: purely combinational `seg`[6:0] → {`bad`, `code`[3:0]}, driven from `samp_q`.
- The top level holds the counter, FSM, output buffer and overrun logic.

## Test plan
- Reset, then hold `seg_in`=7'b0100100 with `out_ready`=1 → one `out_valid` pulse, `out_code`=2, `out_bad`=0, after `STABLE_CYCLES` samples; none while held.
- Apply 0110000 for 3 cycles, then 1000000 held (`STABLE_CYCLES`=4) → only code 0 is emitted, 4 samples after the change.
- Hold 1111001 → code 1; then apply 1111111 → code F; then apply 1011011 → `out_code`=F with `out_bad`=1.
- Emit code 5 (0010010) with `out_ready`=0, then apply 0000010 stable → buffer keeps 5 and `overrun`=1. Assert `out_ready` → 5 transfers, no 6 follows. Pulse `clear_overrun` → 0.
- After code 3 is accepted, apply a 1-cycle glitch to 0000000, then back to 0110000 → no new result.
- Assert `reset` asynchronously mid-window and with `out_valid`=1 → all outputs take their reset values immediately; nothing is emitted after release until a new non-blank pattern is stable.
